// File: rtl/char_motion.sv
// char_motion: per-frame sprite motion and animation controller.
// Samples the synchronized NES buttons on each rising edge of frame_tick and,
// on the following clock, applies walking, jumping/gravity, edge clamping and
// walk-cycle sequencing. Every output is a register.
`timescale 1ns/1ps

module char_motion #(
  parameter int X_START   = 300,
  parameter int X_MAX     = 594,
  parameter int Y_GROUND  = 420,
  parameter int WALK_STEP = 5,
  parameter int JUMP_VEL  = 12,
  parameter int GRAVITY   = 1,
  parameter int MAX_FALL  = 12,
  parameter int ANIM_DIV  = 8
) (
  input  logic       clk,
  input  logic       i_reset,
  input  logic       i_frame_tick,
  input  logic [7:0] i_buttons,
  output logic [9:0] o_char_x,
  output logic [9:0] o_char_y,
  output logic       o_facing_right,
  output logic [9:0] o_anim_row,
  output logic [9:0] o_anim_col,
  output logic       o_airborne,
  output logic       o_frame_done
);

  typedef enum logic {ST_GROUND, ST_AIR} state_t;

  localparam logic [9:0]        XS   = 10'(X_START);
  localparam logic [9:0]        XM   = 10'(X_MAX);
  localparam logic [9:0]        YG   = 10'(Y_GROUND);
  localparam logic [9:0]        WS   = 10'(WALK_STEP);
  localparam logic signed [5:0] JV   = 6'(JUMP_VEL);
  localparam logic signed [5:0] GV   = 6'(GRAVITY);
  localparam logic signed [5:0] MFV  = 6'(MAX_FALL);
  localparam logic [2:0]        DIVL = 3'(ANIM_DIV - 1);

  // Synchronizer carries only the bits the design uses: {A, left, right}.
  logic [2:0]        r_sync1, r_sync2;
  logic [2:0]        r_btn;       // pressed flags snapshotted at the tick: {a, left, right}
  logic              r_tick_d;
  logic              r_armed;     // frame_tick has been seen low since reset
  logic              r_upd;
  state_t            r_state;
  logic signed [5:0] r_vel;
  logic [2:0]        r_div;
  logic [2:0]        r_f;
  logic              r_a_prev;
  logic [9:0]        r_x, r_y, r_row, r_col;
  logic              r_face, r_air, r_frame_done;

  logic              w_tick_rise, w_right, w_left, w_a, w_walk, w_jump;
  logic [10:0]       w_ny;
  logic              w_ny_neg, w_ny_floor;
  logic signed [5:0] w_vel_fall;
  logic [9:0]        w_x_right, w_x_left;
  logic [2:0]        w_f_next, w_div_next;
  logic              w_unused_btn;

  assign w_unused_btn = &{1'b0, i_buttons[7:5], i_buttons[3:2]};

  assign w_tick_rise = i_frame_tick & ~r_tick_d & r_armed;
  assign w_right     = r_btn[0];
  assign w_left      = r_btn[1];
  assign w_a         = r_btn[2];
  assign w_walk      = w_right ^ w_left;
  assign w_jump      = (r_state == ST_GROUND) && w_a && !r_a_prev;

  // Vertical candidate position as an 11-bit value; bit 10 flags a head bump.
  assign w_ny       = {1'b0, r_y} + {{5{r_vel[5]}}, r_vel};
  assign w_ny_neg   = w_ny[10];
  assign w_ny_floor = !w_ny[10] && (w_ny[9:0] >= YG);
  assign w_vel_fall = (r_vel >= MFV - GV) ? MFV : r_vel + GV;

  assign w_x_right = (r_x >= XM - WS) ? XM : r_x + WS;
  assign w_x_left  = (r_x < WS) ? 10'd0 : r_x - WS;

  function automatic logic [9:0] row_of(input logic [2:0] f);
    return (f >= 3'd3) ? 10'd30 : 10'd0;
  endfunction

  function automatic logic [9:0] col_of(input logic [2:0] f);
    case (f)
      3'd1, 3'd4: return 10'd23;
      3'd2, 3'd5: return 10'd46;
      default:    return 10'd0;
    endcase
  endfunction

  // Next walk-cycle frame and divider for the pending update.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    w_f_next   = r_f;
    w_div_next = r_div;
    if (r_state == ST_AIR) begin
      if (w_ny_floor) begin
        w_f_next   = 3'd0;
        w_div_next = 3'd0;
      end else begin
        w_f_next = 3'd4;
      end
    end else if (w_jump) begin
      w_f_next = 3'd4;
    end else if (w_walk) begin
      if (r_div == DIVL) begin
        w_div_next = 3'd0;
        w_f_next   = (r_f == 3'd5) ? 3'd0 : r_f + 3'd1;
      end else begin
        w_div_next = r_div + 3'd1;
      end
    end else begin
      w_f_next   = 3'd0;
      w_div_next = 3'd0;
    end
  end

  // Synchronizer, tick detection and the once-per-frame state/output update.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking throughout so every register sees pre-edge values.
    if (i_reset) begin
      r_sync1      <= 3'b111;
      r_sync2      <= 3'b111;
      r_btn        <= 3'b000;
      r_tick_d     <= 1'b0;
      r_armed      <= 1'b0;
      r_upd        <= 1'b0;
      r_state      <= ST_GROUND;
      r_vel        <= '0;
      r_div        <= '0;
      r_f          <= '0;
      r_a_prev     <= 1'b0;
      r_x          <= XS;
      r_y          <= YG;
      r_face       <= 1'b1;
      r_row        <= '0;
      r_col        <= '0;
      r_air        <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_sync1      <= {i_buttons[4], i_buttons[1], i_buttons[0]};
      r_sync2      <= r_sync1;
      r_tick_d     <= i_frame_tick;
      if (!i_frame_tick) r_armed <= 1'b1;
      r_upd        <= w_tick_rise;
      if (w_tick_rise) r_btn <= ~r_sync2;
      r_frame_done <= r_upd;

      if (r_upd) begin
        r_a_prev <= w_a;
        r_f      <= w_f_next;
        r_div    <= w_div_next;
        r_row    <= row_of(w_f_next);
        r_col    <= col_of(w_f_next);

        if (w_right && !w_left) begin
          r_x    <= w_x_right;
          r_face <= 1'b1;
        end else if (w_left && !w_right) begin
          r_x    <= w_x_left;
          r_face <= 1'b0;
        end

        case (r_state)
          ST_GROUND: begin
            if (w_jump) begin
              r_vel   <= -JV;
              r_state <= ST_AIR;
              r_air   <= 1'b1;
            end
          end
          ST_AIR: begin
            if (w_ny_floor) begin
              r_y     <= YG;
              r_vel   <= '0;
              r_state <= ST_GROUND;
              r_air   <= 1'b0;
            end else if (w_ny_neg) begin
              r_y   <= '0;
              r_vel <= '0;
            end else begin
              r_y   <= w_ny[9:0];
              r_vel <= w_vel_fall;
            end
          end
          default: r_state <= ST_GROUND;
        endcase
      end
    end
  end

  assign o_char_x       = r_x;
  assign o_char_y       = r_y;
  assign o_facing_right = r_face;
  assign o_anim_row     = r_row;
  assign o_anim_col     = r_col;
  assign o_airborne     = r_air;
  assign o_frame_done   = r_frame_done;

endmodule
